// File: rtl/xilinx_dram_sdp_clr.sv
// Simple-dual-port LUT RAM with a self-clearing sweep after reset and on CLR request.
// Read latency 1 edge (OUTREG=0) or 2 edges (OUTREG=1); one write and one read per cycle.
// No backpressure; while BUSY=1, user reads and writes are dropped without any indication.
module xilinx_dram_sdp_clr #(
    parameter int                WIDTH      = 8,
    parameter int                ABITS      = 6,
    parameter int                OUTREG     = 1,
    parameter int                RDW_BYPASS = 0,
    parameter logic [WIDTH-1:0]  CLR_VAL    = {WIDTH{1'b0}}
) (
    input  logic             CLK1,
    input  logic             RST_N,
    input  logic             WEN,
    input  logic [ABITS-1:0] WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             REN,
    input  logic [ABITS-1:0] RADDR,
    input  logic             CLR,
    output logic [WIDTH-1:0] RDATA,
    output logic             RVALID,
    output logic             BUSY
);

    localparam int               DEPTH    = 1 << ABITS;
    localparam logic [ABITS-1:0] LAST_ADR = {ABITS{1'b1}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] cnt_q, cnt_d;

    // Asynchronous read keeps the array in LUT RAM; there is no reset on it.
    logic [WIDTH-1:0] mem [DEPTH];

    logic             ready;
    logic             clr_acc;
    logic             usr_wr;
    logic             rd_acc;
    logic             mem_we;
    logic [ABITS-1:0] mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] rd_sel;

    logic [WIDTH-1:0] rd1_q;
    logic             vld1_q;

    // Access qualification: clear wins over a same-cycle write or read.
    always_comb begin
        ready   = (state_q == ST_READY);
        clr_acc = ready & CLR;
        usr_wr  = ready & WEN & ~CLR;
        rd_acc  = ready & REN & ~CLR;
        mem_we  = ~ready | usr_wr;
        mem_wa  = ready ? WADDR : cnt_q;
        mem_wd  = ready ? WDATA : CLR_VAL;
        rd_word = mem[RADDR];
        rd_sel  = rd_word;
        if ((RDW_BYPASS != 0) && usr_wr && (WADDR == RADDR)) begin
            rd_sel = WDATA;
        end
    end

    // Next-state logic: sweep one address per edge, leave CLEAR after the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ABITS'(1);
                if (cnt_q == LAST_ADR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clr_acc) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Single write port shared by the clear sweep and user writes.
    always_ff @(posedge CLK1) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // First read stage: capture the addressed word; data holds when no read.
    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            rd1_q  <= '0;
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= rd_acc;
            if (rd_acc) begin
                rd1_q <= rd_sel;
            end
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic [WIDTH-1:0] rd2_q;
            logic             vld2_q;

            // Second read stage; an accepted clear drops the in-flight result.
            always_ff @(posedge CLK1 or negedge RST_N) begin
                if (!RST_N) begin
                    rd2_q  <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    vld2_q <= vld1_q & ~clr_acc;
                    if (vld1_q & ~clr_acc) begin
                        rd2_q <= rd1_q;
                    end
                end
            end

            assign RDATA  = rd2_q;
            assign RVALID = vld2_q;
        end else begin : g_noreg
            assign RDATA  = rd1_q;
            assign RVALID = vld1_q;
        end
    endgenerate

    assign BUSY = (state_q == ST_CLEAR);

endmodule
